// File: rtl/pulse_seq_pkg.sv
// pulse_seq_pkg: shared FSM state type and default sizing for the pulse sequencer.
package pulse_seq_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, COUNT, PULSE} state_e;
    localparam int DEF_TW        = 32;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_PULSE_LEN = 1;
endpackage

// File: rtl/pulse_seq_fifo.sv
// pulse_seq_fifo: synchronous DEPTH x TW delay FIFO with occupancy count; caller guarantees no overflow/underflow.
module pulse_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int TW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [TW-1:0]            wdata,
    input  logic                     pop,
    output logic [TW-1:0]            rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [TW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    always_ff @(posedge clk)
        if (push) mem_q[wptr_q] <= wdata;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop) rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    assign rdata = mem_q[rptr_q];
    assign count = count_q;
endmodule

// File: rtl/pulse_sequencer.sv
// pulse_sequencer: plays queued delays as timed pulses (pulse D+2 cycles after each pop).
// Define PULSE_SEQ_LOOP_EN to add loop_en, which recirculates each popped delay to the FIFO tail.
module pulse_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int TW        = DEF_TW,
    parameter int PULSE_LEN = DEF_PULSE_LEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TW-1:0]          in_delay,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   start,
    input  logic                   stop,
`ifdef PULSE_SEQ_LOOP_EN
    input  logic                   loop_en,
`endif
    output logic                   pulse_out,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    state_e        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d, head, push_data;
    logic          pulse_q, done_q, done_d, push, pop, loop_push, empty, space;
    assign empty = fifo_count == '0;
    assign space = fifo_count < CW'(DEPTH);
    assign busy  = state_q != IDLE;
    // A stop during LOAD cancels the pop so the queued delay survives the abort.
    assign pop   = state_q == LOAD && !stop;
`ifdef PULSE_SEQ_LOOP_EN
    assign loop_push = loop_en && pop;
    assign in_ready  = space && !(loop_en && busy);
`else
    assign loop_push = 1'b0;
    assign in_ready  = space;
`endif
    assign push      = (in_valid && in_ready) || loop_push;
    assign push_data = loop_push ? head : in_delay;
    pulse_seq_fifo #(.DEPTH(DEPTH), .TW(TW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count)
    );
    // The counter holds the delay in COUNT and the remaining pulse width in PULSE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (stop) state_d = IDLE;
        else
            case (state_q)
                IDLE:  state_d = start && !empty ? LOAD : IDLE;
                LOAD: begin
                    state_d = COUNT;
                    cnt_d   = head;
                end
                COUNT: begin
                    state_d = cnt_q == '0 ? PULSE : COUNT;
                    cnt_d   = cnt_q == '0 ? TW'(PULSE_LEN - 1) : cnt_q - TW'(1);
                end
                PULSE: begin
                    state_d = cnt_q != '0 ? PULSE : empty ? IDLE : LOAD;
                    cnt_d   = cnt_q != '0 ? cnt_q - TW'(1) : cnt_q;
                    done_d  = cnt_q == '0 && empty;
                end
            endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= state_d == PULSE;
            done_q  <= done_d;
        end
    assign pulse_out = pulse_q;
    assign done      = done_q;
endmodule
